crc8_stream_arbiter: RTL and testbench

Round-robin controller that shares one CRC8816 checker between two requesters. Each requester hands over a full DATA_LENGTH-bit packet with a request/acknowledge handshake. The arbiter serializes the packet MSB-byte-first into the checker's byte stream (valid/last), waits for the checker's done, and returns the match result to the granted requester. It sits between the packet sources and the CRC8816 instance and is the only driver of that instance's inputs.

---
 rtl/crc8_stream_arbiter.sv | 138 +++++++++++++
 tb/tb_crc8_stream_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/crc8_stream_arbiter.sv
// Round-robin front end that shares one CRC8816 checker between two packet sources.
// Packets are sent to the checker MSB byte first, and the checker's result goes back to the channel that owns the packet.
module crc8_stream_arbiter #(
    parameter int DATA_LENGTH       = 32,
    parameter int DATA_LENGTH_BYTES = DATA_LENGTH / 8,
    parameter int DONE_TIMEOUT      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             i_req,
    input  logic [DATA_LENGTH-1:0] i_data0,
    input  logic [DATA_LENGTH-1:0] i_data1,
    output logic [1:0]             o_ack,
    output logic [1:0]             o_resp_valid,
    output logic                   o_resp_match,
    output logic                   o_resp_timeout,
    output logic                   o_busy,
    output logic                   crc_valid,
    output logic                   crc_last,
    output logic [7:0]             crc_data,
    input  logic                   crc_match,
    input  logic                   crc_done
);

    localparam int CW = $clog2(DONE_TIMEOUT + 1);
    localparam int BW = (DATA_LENGTH_BYTES > 1) ? $clog2(DATA_LENGTH_BYTES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]             state_reg;
    logic                   last_reg;
    logic                   grant_reg;
    logic [DATA_LENGTH-1:0] shift_reg;
    logic [BW-1:0]          byte_cnt_reg;
    logic [CW-1:0]          tcnt_reg;
    logic [1:0]             ack_reg;
    logic [1:0]             resp_valid_reg;
    logic                   resp_match_reg;
    logic                   resp_timeout_reg;
    logic                   busy_reg;
    logic                   crc_valid_reg;
    logic                   crc_last_reg;
    logic [7:0]             crc_data_reg;

    logic                   grant_idx;
    logic [DATA_LENGTH-1:0] grant_data;

    // On a tie the channel that did not win last time is served.
    always_comb begin
        grant_idx  = (i_req == 2'b11) ? ~last_reg : i_req[1];
        grant_data = grant_idx ? i_data1 : i_data0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            last_reg         <= 1'b1;
            grant_reg        <= 1'b0;
            shift_reg        <= '0;
            byte_cnt_reg     <= '0;
            tcnt_reg         <= '0;
            ack_reg          <= '0;
            resp_valid_reg   <= '0;
            resp_match_reg   <= 1'b0;
            resp_timeout_reg <= 1'b0;
            busy_reg         <= 1'b0;
            crc_valid_reg    <= 1'b0;
            crc_last_reg     <= 1'b0;
            crc_data_reg     <= '0;
        end else begin
            ack_reg        <= '0;
            resp_valid_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (|i_req) begin
                        ack_reg[grant_idx] <= 1'b1;
                        grant_reg          <= grant_idx;
                        last_reg           <= grant_idx;
                        crc_data_reg       <= grant_data[DATA_LENGTH-1 -: 8];
                        shift_reg          <= grant_data << 8;
                        crc_valid_reg      <= 1'b1;
                        crc_last_reg       <= 1'b0;
                        byte_cnt_reg       <= '0;
                        busy_reg           <= 1'b1;
                        state_reg          <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (byte_cnt_reg == BW'(DATA_LENGTH_BYTES - 1)) begin
                        crc_valid_reg <= 1'b0;
                        crc_last_reg  <= 1'b0;
                        crc_data_reg  <= '0;
                        tcnt_reg      <= '0;
                        state_reg     <= ST_WAIT;
                    end else begin
                        crc_data_reg <= shift_reg[DATA_LENGTH-1 -: 8];
                        shift_reg    <= shift_reg << 8;
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        crc_last_reg <= (byte_cnt_reg == BW'(DATA_LENGTH_BYTES - 2));
                    end
                end
                ST_WAIT: begin
                    // A done arriving on the expiry cycle still counts as a real result.
                    if (crc_done) begin
                        resp_valid_reg[grant_reg] <= 1'b1;
                        resp_match_reg            <= crc_match;
                        resp_timeout_reg          <= 1'b0;
                        state_reg                 <= ST_RESP;
                    end else if (tcnt_reg == CW'(DONE_TIMEOUT)) begin
                        resp_valid_reg[grant_reg] <= 1'b1;
                        resp_match_reg            <= 1'b0;
                        resp_timeout_reg          <= 1'b1;
                        state_reg                 <= ST_RESP;
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ack          = ack_reg;
    assign o_resp_valid   = resp_valid_reg;
    assign o_resp_match   = resp_match_reg;
    assign o_resp_timeout = resp_timeout_reg;
    assign o_busy         = busy_reg;
    assign crc_valid      = crc_valid_reg;
    assign crc_last       = crc_last_reg;
    assign crc_data       = crc_data_reg;

endmodule

// File: tb/tb_crc8_stream_arbiter.sv
// Directed bench for crc8_stream_arbiter: the bench plays the checker by driving done and match at chosen cycles.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_crc8_stream_arbiter;

    localparam int N  = 4;
    localparam int DT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  i_req;
    logic [31:0] i_data0;
    logic [31:0] i_data1;
    logic [1:0]  o_ack;
    logic [1:0]  o_resp_valid;
    logic        o_resp_match;
    logic        o_resp_timeout;
    logic        o_busy;
    logic        crc_valid;
    logic        crc_last;
    logic [7:0]  crc_data;
    logic        crc_match;
    logic        crc_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crc8_stream_arbiter #(
        .DATA_LENGTH(32),
        .DATA_LENGTH_BYTES(4),
        .DONE_TIMEOUT(DT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req(i_req),
        .i_data0(i_data0),
        .i_data1(i_data1),
        .o_ack(o_ack),
        .o_resp_valid(o_resp_valid),
        .o_resp_match(o_resp_match),
        .o_resp_timeout(o_resp_timeout),
        .o_busy(o_busy),
        .crc_valid(crc_valid),
        .crc_last(crc_last),
        .crc_data(crc_data),
        .crc_match(crc_match),
        .crc_done(crc_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"}, o_ack, 0);
        check({tag, "_resp_valid"}, o_resp_valid, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_crc_valid"}, crc_valid, 0);
        check({tag, "_crc_last"}, crc_last, 0);
        check({tag, "_crc_data"}, crc_data, 0);
    endtask

    // Called in the cycle the request is presented; returns in the IDLE cycle after RESP.
    // dly > 0: done is driven in cycle N+dly; dly == 0: the checker never answers.
    task automatic do_packet(input logic [1:0] req, input int g, input int dly,
                             input logic m, input bit keep);
        logic [31:0] d;
        logic [31:0] exp_byte;
        i_req = req;
        tick;
        $display("packet: req=%b expect grant ch%0d, ack=%b", req, g, o_ack);
        check("ack", o_ack, 32'd1 << g);
        check("busy_send", o_busy, 1);
        d = (g == 1) ? i_data1 : i_data0;
        if (!keep) i_req = 2'b00;
        for (int k = 0; k < N; k++) begin
            exp_byte = (d >> (24 - 8 * k)) & 32'hFF;
            check("send_valid", crc_valid, 1);
            check("send_data", crc_data, exp_byte);
            check("send_last", crc_last, (k == N - 1) ? 1 : 0);
            if (k < N - 1) tick;
        end
        tick;
        check("wait_valid", crc_valid, 0);
        check("wait_last", crc_last, 0);
        check("wait_data", crc_data, 0);
        if (dly > 0) begin
            for (int c = 1; c < dly; c++) begin
                check("no_early_resp", o_resp_valid, 0);
                tick;
            end
            crc_done  = 1'b1;
            crc_match = m;
            tick;
            crc_done  = 1'b0;
            crc_match = 1'b0;
            check("resp_valid", o_resp_valid, 32'd1 << g);
            check("resp_match", o_resp_match, m);
            check("resp_timeout", o_resp_timeout, 0);
        end else begin
            for (int c = 0; c <= DT; c++) begin
                check("no_early_resp", o_resp_valid, 0);
                tick;
            end
            check("to_resp_valid", o_resp_valid, 32'd1 << g);
            check("to_resp_match", o_resp_match, 0);
            check("to_resp_timeout", o_resp_timeout, 1);
        end
        check("busy_resp", o_busy, 1);
        $display("response: ch%0d valid=%b match=%b timeout=%b", g, o_resp_valid, o_resp_match,
                 o_resp_timeout);
        tick;
        check("resp_pulse", o_resp_valid, 0);
        check("busy_idle", o_busy, 0);
        check("match_hold", o_resp_match, (dly > 0) ? m : 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        i_req     = 2'b00;
        i_data0   = '0;
        i_data1   = '0;
        crc_match = 1'b0;
        crc_done  = 1'b0;

        repeat (3) tick;
        check_idle_outputs("reset");
        check("reset_match", o_resp_match, 0);
        check("reset_timeout", o_resp_timeout, 0);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            check("quiet_valid", crc_valid, 0);
            check("quiet_busy", o_busy, 0);
        end
        $display("reset: outputs idle for 10 cycles");

        i_data0 = 32'hDEADBEEF;
        do_packet(2'b01, 0, 2, 1'b1, 1'b0);

        i_data1 = 32'hDEADBEEE;
        do_packet(2'b10, 1, 1, 1'b0, 1'b0);

        i_data0 = 32'h11223344;
        i_data1 = 32'hA5A5A5A5;
        do_packet(2'b11, 0, 2, 1'b1, 1'b1);
        do_packet(2'b11, 1, 3, 1'b0, 1'b1);
        do_packet(2'b11, 0, 1, 1'b1, 1'b1);
        do_packet(2'b11, 1, 2, 1'b1, 1'b0);

        i_data0 = 32'hCAFEF00D;
        do_packet(2'b01, 0, 0, 1'b0, 1'b0);
        crc_done  = 1'b1;
        crc_match = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            check_idle_outputs("late_done");
            check("late_match", o_resp_match, 0);
        end
        crc_done  = 1'b0;
        crc_match = 1'b0;
        $display("late done: ignored in IDLE");

        i_data0 = 32'h12345678;
        i_req   = 2'b01;
        tick;
        check("abort_ack", o_ack, 1);
        i_req = 2'b00;
        tick;
        check("abort_byte1", crc_data, 32'h34);
        reset = 1'b1;
        tick;
        check_idle_outputs("abort");
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick;
            check("abort_no_resp", o_resp_valid, 0);
            check("abort_busy", o_busy, 0);
        end
        $display("abort: reset during SEND cleared all outputs");

        i_data0 = 32'h0F0F0F0F;
        i_data1 = 32'hF0F0F0F0;
        do_packet(2'b11, 0, 2, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
